// File: rtl/regfile_pkg.sv
// Shared types, default sizes and helpers for the multi-port register file.
// Included by every regfile source through import regfile_pkg::*.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 16;
    localparam int PC_IDX_DEF   = 15;

    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read mux of the register file, with optional write forwarding.
// Build option: REGFILE_BYPASS_EN enables same-cycle write-to-read forwarding.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int PC_IDX   = PC_IDX_DEF,
    parameter int AW       = addr_w(NUM_REGS)
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic                            busy,
    input  logic [AW-1:0]                   rd_addr,
    input  logic                            wr_fwd,
    input  logic [AW-1:0]                   wr_addr,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic                            pc_fwd,
    input  logic [DATA_W-1:0]               pc_data,
    output logic [DATA_W-1:0]               rd_data
);

    localparam logic [AW-1:0] PC_ADDR = AW'(PC_IDX);

    logic in_range;

    // Only a non-power-of-two register count leaves unmapped addresses to filter.
    if (NUM_REGS == (1 << AW)) begin : g_full
        assign in_range = 1'b1;
    end else begin : g_part
        localparam logic [AW-1:0] LIMIT = AW'(NUM_REGS);
        assign in_range = (rd_addr < LIMIT);
    end

`ifdef REGFILE_BYPASS_EN
    always_comb begin
        rd_data = '0;
        if (!busy && in_range) begin
            if (wr_fwd && (rd_addr == wr_addr)) begin
                rd_data = wr_data;
            end else if (pc_fwd && (rd_addr == PC_ADDR)) begin
                rd_data = pc_data;
            end else begin
                rd_data = regs[rd_addr];
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{wr_fwd, wr_addr, wr_data, pc_fwd, pc_data, PC_ADDR};

    always_comb begin
        rd_data = '0;
        if (!busy && in_range) begin
            rd_data = regs[rd_addr];
        end
    end
`endif

endmodule

// File: rtl/banco_registros_multipuerto.sv
// Multi-port CPU register file: storage, clear sequencer and write decode.
// Build option: REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module banco_registros_multipuerto
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int PC_IDX   = PC_IDX_DEF,
    localparam int AW      = addr_w(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear_req,
    input  logic                           wr_en,
    input  logic [AW-1:0]                  wr_addr,
    input  logic [DATA_W-1:0]              wr_data,
    input  logic                           pc_wr_en,
    input  logic [DATA_W-1:0]              pc_data,
    input  logic [NUM_RD-1:0][AW-1:0]      rd_addr,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data,
    output logic                           busy
);

    localparam logic [AW-1:0] LAST_IDX = AW'(NUM_REGS - 1);
    localparam logic [AW-1:0] PC_ADDR  = AW'(PC_IDX);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    state_t                          state;
    logic [AW-1:0]                   clr_idx;
    logic                            wr_in_range;
    logic                            run_write;
    logic                            wr_hit;
    logic                            pc_hit;

    if (NUM_REGS == (1 << AW)) begin : g_wr_full
        assign wr_in_range = 1'b1;
    end else begin : g_wr_part
        localparam logic [AW-1:0] LIMIT = AW'(NUM_REGS);
        assign wr_in_range = (wr_addr < LIMIT);
    end

    assign busy = (state == CLEAR);

    // A clear request wins over any write presented in the same cycle.
    assign run_write = (state == RUN) && !clear_req;
    assign wr_hit    = run_write && wr_en && wr_in_range;
    assign pc_hit    = run_write && pc_wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else if (state == CLEAR) begin
            if (clr_idx == LAST_IDX) begin
                state <= RUN;
            end else begin
                clr_idx <= clr_idx + AW'(1);
            end
        end else if (clear_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end
    end

    // Register contents survive the reset edge itself; the sequencer zeroes them afterwards.
    // The general write comes last so it overrides the PC path on a collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                regs[clr_idx] <= '0;
            end else begin
                if (pc_hit) begin
                    regs[PC_ADDR] <= pc_data;
                end
                if (wr_hit) begin
                    regs[wr_addr] <= wr_data;
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .PC_IDX   (PC_IDX),
            .AW       (AW)
        ) u_port (
            .regs    (regs),
            .busy    (busy),
            .rd_addr (rd_addr[p]),
            .wr_fwd  (wr_hit),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .pc_fwd  (pc_hit),
            .pc_data (pc_data),
            .rd_data (rd_data[p])
        );
    end

endmodule

// File: tb/tb_banco_registros_multipuerto.sv
// Self-checking bench for banco_registros_multipuerto (16 x 32, two read ports).
// Honours REGFILE_BYPASS_EN when it is defined for the build.
module tb_banco_registros_multipuerto;

    logic             clk;
    logic             rst;
    logic             clear_req;
    logic             wr_en;
    logic [3:0]       wr_addr;
    logic [31:0]      wr_data;
    logic             pc_wr_en;
    logic [31:0]      pc_data;
    logic [1:0][3:0]  rd_addr;
    logic [1:0][31:0] rd_data;
    logic             busy;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [16];
    bit          m_busy = 1'b1;
    int          m_pos  = 0;

    typedef struct {
        logic        we;
        logic [3:0]  wa;
        logic [31:0] wd;
        logic        pe;
        logic [31:0] pd;
        logic [3:0]  ra0;
        logic [3:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t vecs [9];

    banco_registros_multipuerto dut (
        .clk       (clk),
        .rst       (rst),
        .clear_req (clear_req),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pc_wr_en  (pc_wr_en),
        .pc_data   (pc_data),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference read: zero while clearing, otherwise the stored word, optionally forwarded.
    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        if (m_busy) return 32'h0;
`ifdef REGFILE_BYPASS_EN
        if (!clear_req) begin
            if (wr_en && (a == wr_addr)) return wr_data;
            if (pc_wr_en && (a == 4'd15)) return pc_data;
        end
`endif
        return mem[int'(a)];
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_busy = 1'b1;
            m_pos  = 0;
        end else if (m_busy) begin
            mem[m_pos] = 32'h0;
            m_pos++;
            if (m_pos == 16) m_busy = 1'b0;
        end else if (clear_req) begin
            m_busy = 1'b1;
            m_pos  = 0;
        end else begin
            if (pc_wr_en) mem[15] = pc_data;
            if (wr_en) mem[int'(wr_addr)] = wr_data;
        end
    endtask

    task automatic set_idle();
        rst       = 1'b0;
        clear_req = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = 4'd0;
        wr_data   = 32'h0;
        pc_wr_en  = 1'b0;
        pc_data   = 32'h0;
        rd_addr   = '0;
    endtask

    task automatic sample_check();
        @(negedge clk);
        check_output("busy", {31'b0, busy}, {31'b0, m_busy});
        check_output("rd0", rd_data[0], exp_rd(rd_addr[0]));
        check_output("rd1", rd_data[1], exp_rd(rd_addr[1]));
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic apply_stimulus();
        sample_check();
        advance();
    endtask

    // Clear edges while busy, with junk writes and random reads that must all be ignored.
    task automatic count_busy(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            wr_en      = 1'b1;
            wr_addr    = 4'($urandom_range(0, 15));
            wr_data    = $urandom;
            pc_wr_en   = 1'b1;
            pc_data    = $urandom;
            clear_req  = ($urandom_range(0, 1) == 1);
            rd_addr[0] = 4'($urandom_range(0, 15));
            rd_addr[1] = 4'($urandom_range(0, 15));
            apply_stimulus();
            n++;
        end
        set_idle();
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) begin
            rd_addr[0] = 4'(2 * i);
            rd_addr[1] = 4'(2 * i + 1);
            apply_stimulus();
        end
    endtask

    int n;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        vecs[0] = '{1'b1, 4'd3,  32'hDEADBEEF, 1'b0, 32'h0,   4'd4,  4'd4,  32'h0,        32'h0};
        vecs[1] = '{1'b0, 4'd0,  32'h0,        1'b0, 32'h0,   4'd3,  4'd3,  32'hDEADBEEF, 32'hDEADBEEF};
        vecs[2] = '{1'b0, 4'd0,  32'h0,        1'b0, 32'h0,   4'd3,  4'd4,  32'hDEADBEEF, 32'h0};
        vecs[3] = '{1'b1, 4'd15, 32'h200,      1'b1, 32'h100, 4'd3,  4'd0,  32'hDEADBEEF, 32'h0};
        vecs[4] = '{1'b0, 4'd0,  32'h0,        1'b0, 32'h0,   4'd15, 4'd3,  32'h200,      32'hDEADBEEF};
        vecs[5] = '{1'b0, 4'd0,  32'h0,        1'b1, 32'h104, 4'd3,  4'd0,  32'hDEADBEEF, 32'h0};
        vecs[6] = '{1'b0, 4'd0,  32'h0,        1'b0, 32'h0,   4'd15, 4'd15, 32'h104,      32'h104};
        vecs[7] = '{1'b1, 4'd7,  32'hA5A5A5A5, 1'b0, 32'h0,   4'd15, 4'd2,  32'h104,      32'h0};
        vecs[8] = '{1'b0, 4'd0,  32'h0,        1'b0, 32'h0,   4'd7,  4'd15, 32'hA5A5A5A5, 32'h104};

        set_idle();
        rst = 1'b1;
        advance();
        check_output("reset_busy", {31'b0, busy}, 32'h1);
        check_output("reset_rd0", rd_data[0], 32'h0);
        check_output("reset_rd1", rd_data[1], 32'h0);
        rst = 1'b0;

        count_busy(n);
        check_output("clear_len", 32'(n), 32'd16);
        read_all();

        for (int i = 0; i < 9; i++) begin
            set_idle();
            wr_en      = vecs[i].we;
            wr_addr    = vecs[i].wa;
            wr_data    = vecs[i].wd;
            pc_wr_en   = vecs[i].pe;
            pc_data    = vecs[i].pd;
            rd_addr[0] = vecs[i].ra0;
            rd_addr[1] = vecs[i].ra1;
            sample_check();
            check_output($sformatf("vec%0d_busy", i), {31'b0, busy}, 32'h0);
            check_output($sformatf("vec%0d_rd0", i), rd_data[0], vecs[i].e0);
            check_output($sformatf("vec%0d_rd1", i), rd_data[1], vecs[i].e1);
            advance();
        end
        set_idle();

        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h1234;
        apply_stimulus();
        wr_data = 32'h55; rd_addr[0] = 4'd5;
        sample_check();
`ifdef REGFILE_BYPASS_EN
        check_output("bypass_same", rd_data[0], 32'h55);
`else
        check_output("bypass_same", rd_data[0], 32'h1234);
`endif
        advance();
        set_idle();
        rd_addr[0] = 4'd5;
        sample_check();
        check_output("bypass_next", rd_data[0], 32'h55);
        advance();

        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = $urandom | 32'h1;
            rd_addr[0] = 4'(i); rd_addr[1] = 4'((i + 1) % 16);
            apply_stimulus();
        end
        set_idle();
        clear_req = 1'b1; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hFFFF;
        rd_addr[0] = 4'd2;
        apply_stimulus();
        set_idle();
        count_busy(n);
        check_output("clear_req_len", 32'(n), 32'd16);
        rd_addr[0] = 4'd2;
        sample_check();
        check_output("clear_req_reg2", rd_data[0], 32'h0);
        advance();
        read_all();

        rst = 1'b1;
        apply_stimulus();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) apply_stimulus();
        rst = 1'b1;
        apply_stimulus();
        rst = 1'b0;
        count_busy(n);
        check_output("restart_len", 32'(n), 32'd16);

        for (int c = 0; c < 400; c++) begin
            rst        = ($urandom_range(0, 199) == 0);
            clear_req  = ($urandom_range(0, 59) == 0);
            wr_en      = ($urandom_range(0, 1) == 1);
            wr_addr    = 4'($urandom_range(0, 15));
            wr_data    = $urandom;
            pc_wr_en   = ($urandom_range(0, 3) == 0);
            pc_data    = $urandom;
            rd_addr[0] = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            rd_addr[1] = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            apply_stimulus();
        end
        set_idle();
        apply_stimulus();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
